// File: rtl/von_neumann_update_pkg.sv
// -----------------------------------------------------------------------------
// von_neumann_update_pkg
// Shared constants for the Von Neumann cell-update block:
//   - FSM state encoding (IDLE / ACC / CALC)
//   - cell value width
//   - default diffusion shift
// No ports; imported by von_neumann_update and vn_clamp_u8.
// -----------------------------------------------------------------------------
package von_neumann_update_pkg;

    // Cell values are unsigned bytes; the datapath widths below are derived
    // from this width and are only valid for 8.
    localparam int CELL_WIDTH         = 8;

    // Diffusion rate: delta = (sum - 4*C) >>> DIFF_SHIFT, legal range 1..4.
    localparam int DEFAULT_DIFF_SHIFT = 2;

    // Accumulator holds the sum of four neighbours (max 4*255 = 1020).
    localparam int ACC_WIDTH          = 10;

    // FSM state encoding, kept as plain constants for legacy compatibility.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_CALC = 2'd2;

    typedef logic [1:0] fsmState_t;

endpackage

// File: rtl/vn_clamp_u8.sv
// -----------------------------------------------------------------------------
// vn_clamp_u8
// Clamps a signed 12-bit intermediate result into the unsigned byte range.
// Ports:
//   resultIn  in  12 (signed)  raw result C + delta
//   clampVal  out 8            result limited to 0..255
//   satFlag   out 1            high when the limit was applied
// Purely combinational; the caller registers both outputs.
// -----------------------------------------------------------------------------
module vn_clamp_u8
    import von_neumann_update_pkg::*;
(
    input  logic signed [11:0]           resultIn,
    output logic        [CELL_WIDTH-1:0] clampVal,
    output logic                         satFlag
);

    // Clamp: sign bit set means below zero, any of bits 10..8 set means above 255.
    always_comb begin
        clampVal = 8'd0;
        satFlag  = 1'b0;
        if (resultIn[11]) begin
            clampVal = 8'd0;
            satFlag  = 1'b1;
        end else if (resultIn[10:8] != 3'b000) begin
            clampVal = 8'd255;
            satFlag  = 1'b1;
        end else begin
            clampVal = resultIn[7:0];
            satFlag  = 1'b0;
        end
    end

endmodule

// File: rtl/von_neumann_update.sv
// -----------------------------------------------------------------------------
// von_neumann_update
// One diffusion step of a Von Neumann cellular automaton cell:
//   NEXT_VAL = clamp(C + ((N + E + S + W - 4*C) >>> DIFF_SHIFT), 0, 255)
// The four neighbours are accumulated serially (one per clock) from a snapshot
// taken when Start is accepted, then the result is computed in one CALC cycle.
// Ports:
//   Clk         in   clock, rising edge
//   Reset       in   asynchronous active-low reset
//   Start       in   request an update; only sampled in IDLE
//   CENTER_VAL  in   8  current cell value
//   NORTH_VAL, EAST_VAL, SOUTH_VAL, WEST_VAL  in  8  neighbour values
//   NEXT_VAL    out  8  registered updated value (held between updates)
//   Done        out  1  one-cycle pulse when NEXT_VAL has just been updated
//   Busy        out  1  high while the FSM is not in IDLE
//   Saturated   out  1  registered: last result was clamped
//   GEN_COUNT   out  8  number of completed updates, wraps at 256
// -----------------------------------------------------------------------------
module von_neumann_update
    import von_neumann_update_pkg::*;
#(
    parameter int WIDTH      = CELL_WIDTH,
    parameter int DIFF_SHIFT = DEFAULT_DIFF_SHIFT
)
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] CENTER_VAL,
    input  logic [WIDTH-1:0] NORTH_VAL,
    input  logic [WIDTH-1:0] EAST_VAL,
    input  logic [WIDTH-1:0] SOUTH_VAL,
    input  logic [WIDTH-1:0] WEST_VAL,
    output logic [WIDTH-1:0] NEXT_VAL,
    output logic             Done,
    output logic             Busy,
    output logic             Saturated,
    output logic [WIDTH-1:0] GEN_COUNT
);

    fsmState_t               state_r;
    logic [1:0]              idx_r;
    logic [ACC_WIDTH-1:0]    acc_r;
    logic [WIDTH-1:0]        snapC_r;
    logic [WIDTH-1:0]        snapN_r;
    logic [WIDTH-1:0]        snapE_r;
    logic [WIDTH-1:0]        snapS_r;
    logic [WIDTH-1:0]        snapW_r;

    logic [WIDTH-1:0]        neighbour_s;
    logic signed [10:0]      diff_s;
    logic signed [10:0]      delta_s;
    logic signed [11:0]      result_s;
    logic [WIDTH-1:0]        clampVal_s;
    logic                    satFlag_s;

    // Neighbour select for the serial accumulation, order N, E, S, W.
    always_comb begin
        neighbour_s = snapN_r;
        case (idx_r)
            2'd0:    neighbour_s = snapN_r;
            2'd1:    neighbour_s = snapE_r;
            2'd2:    neighbour_s = snapS_r;
            2'd3:    neighbour_s = snapW_r;
            default: neighbour_s = snapN_r;
        endcase
    end

    // Laplacian-style difference and its scaled update. Both operands are
    // zero-extended to 11 bits, so the range -1020..1020 fits without overflow;
    // the arithmetic shift on a signed value gives floor rounding.
    always_comb begin
        diff_s   = $signed({1'b0, acc_r}) - $signed({1'b0, snapC_r, 2'b00});
        delta_s  = diff_s >>> DIFF_SHIFT;
        result_s = $signed({4'b0000, snapC_r}) + $signed({delta_s[10], delta_s});
    end

    vn_clamp_u8 uClamp (
        .resultIn (result_s),
        .clampVal (clampVal_s),
        .satFlag  (satFlag_s)
    );

    // Control FSM plus snapshot, accumulator and registered result outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r   <= ST_IDLE;
            idx_r     <= 2'd0;
            acc_r     <= 10'd0;
            snapC_r   <= 8'd0;
            snapN_r   <= 8'd0;
            snapE_r   <= 8'd0;
            snapS_r   <= 8'd0;
            snapW_r   <= 8'd0;
            NEXT_VAL  <= 8'd0;
            Saturated <= 1'b0;
            Done      <= 1'b0;
            GEN_COUNT <= 8'd0;
        end else begin
            // Done is a single-cycle pulse; only the CALC branch raises it.
            Done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (Start) begin
                        snapC_r <= CENTER_VAL;
                        snapN_r <= NORTH_VAL;
                        snapE_r <= EAST_VAL;
                        snapS_r <= SOUTH_VAL;
                        snapW_r <= WEST_VAL;
                        acc_r   <= 10'd0;
                        idx_r   <= 2'd0;
                        state_r <= ST_ACC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACC: begin
                    acc_r <= acc_r + {2'b00, neighbour_s};
                    idx_r <= idx_r + 2'd1;
                    if (idx_r == 2'd3) begin
                        state_r <= ST_CALC;
                    end else begin
                        state_r <= ST_ACC;
                    end
                end
                ST_CALC: begin
                    NEXT_VAL  <= clampVal_s;
                    Saturated <= satFlag_s;
                    Done      <= 1'b1;
                    GEN_COUNT <= GEN_COUNT + 8'd1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy = (state_r != ST_IDLE);

endmodule

// File: tb/tb_von_neumann_update.sv
// -----------------------------------------------------------------------------
// tb_von_neumann_update
// Two instances: dutA uses DIFF_SHIFT=2, dutB uses DIFF_SHIFT=1. Stimulus tasks
// push the expected result into a per-instance queue when Start is driven;
// a negedge monitor pops and compares whenever Done is seen.
// -----------------------------------------------------------------------------
module tb_von_neumann_update;

    logic       clk;
    logic       resetN;
    logic       startA, startB;
    logic [7:0] cA, nA, eA, sA, wA;
    logic [7:0] cB, nB, eB, sB, wB;
    logic [7:0] nextA, nextB, genA, genB;
    logic       doneA, doneB, busyA, busyB, satA, satB;

    von_neumann_update #(.WIDTH(8), .DIFF_SHIFT(2)) dutA (
        .Clk(clk), .Reset(resetN), .Start(startA),
        .CENTER_VAL(cA), .NORTH_VAL(nA), .EAST_VAL(eA), .SOUTH_VAL(sA), .WEST_VAL(wA),
        .NEXT_VAL(nextA), .Done(doneA), .Busy(busyA), .Saturated(satA), .GEN_COUNT(genA)
    );

    von_neumann_update #(.WIDTH(8), .DIFF_SHIFT(1)) dutB (
        .Clk(clk), .Reset(resetN), .Start(startB),
        .CENTER_VAL(cB), .NORTH_VAL(nB), .EAST_VAL(eB), .SOUTH_VAL(sB), .WEST_VAL(wB),
        .NEXT_VAL(nextB), .Done(doneB), .Busy(busyB), .Saturated(satB), .GEN_COUNT(genB)
    );

    typedef struct {
        logic [7:0] val;
        logic       sat;
        logic [7:0] gen;
        int         doneCyc;
    } exp_t;

    typedef struct {
        bit         useB;
        logic [7:0] c, n, e, s, w;
        logic [7:0] expVal;
        logic       expSat;
    } vec_t;

    exp_t qA[$];
    exp_t qB[$];
    vec_t vecs[13];

    int nChecks = 0;
    int nFail   = 0;
    int cyc     = 0;
    int modelGenA = 0;
    int modelGenB = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkDone(input string tag, input logic [7:0] v, input logic st,
                             input logic [7:0] g, input logic bz, input exp_t e);
        check({tag, ".NEXT_VAL"},  {24'd0, v}, {24'd0, e.val});
        check({tag, ".Saturated"}, {31'd0, st}, {31'd0, e.sat});
        check({tag, ".GEN_COUNT"}, {24'd0, g}, {24'd0, e.gen});
        check({tag, ".Busy@Done"}, {31'd0, bz}, 32'd0);
        check({tag, ".latency"},   cyc, e.doneCyc);
    endtask

    // Scoreboard monitor: every Done must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (doneA) begin
            if (qA.size() == 0) begin
                nChecks++; nFail++;
                $display("FAIL unexpectedDoneA: got Done=1 expected Done=0 (cycle %0d)", cyc);
            end else begin
                e = qA.pop_front();
                checkDone("A", nextA, satA, genA, busyA, e);
            end
        end
        if (doneB) begin
            if (qB.size() == 0) begin
                nChecks++; nFail++;
                $display("FAIL unexpectedDoneB: got Done=1 expected Done=0 (cycle %0d)", cyc);
            end else begin
                e = qB.pop_front();
                checkDone("B", nextB, satB, genB, busyB, e);
            end
        end
    end

    // Push one expectation. Start is driven at a negedge with cyc==m; it is
    // sampled at edge m+1, ACC runs on edges m+2..m+5, CALC on edge m+6.
    task automatic pushExp(input bit useB, input logic [7:0] v, input logic st, input int doneCyc);
        exp_t e;
        e.val = v; e.sat = st; e.doneCyc = doneCyc;
        if (useB) begin
            modelGenB = (modelGenB + 1) % 256;
            e.gen = modelGenB[7:0];
            qB.push_back(e);
        end else begin
            modelGenA = (modelGenA + 1) % 256;
            e.gen = modelGenA[7:0];
            qA.push_back(e);
        end
    endtask

    task automatic startPulse(input vec_t v);
        @(negedge clk);
        if (v.useB) begin
            cB = v.c; nB = v.n; eB = v.e; sB = v.s; wB = v.w; startB = 1'b1;
        end else begin
            cA = v.c; nA = v.n; eA = v.e; sA = v.s; wA = v.w; startA = 1'b1;
        end
        pushExp(v.useB, v.expVal, v.expSat, cyc + 6);
        @(negedge clk);
        startA = 1'b0;
        startB = 1'b0;
        check(v.useB ? "B.BusyAfterStart" : "A.BusyAfterStart",
              {31'd0, (v.useB ? busyB : busyA)}, 32'd1);
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget && (qA.size() != 0 || qB.size() != 0); i++) @(negedge clk);
        if (qA.size() != 0 || qB.size() != 0) begin
            nChecks++; nFail++;
            $display("FAIL drainTimeout: got %0d outstanding expected 0", qA.size() + qB.size());
            qA.delete();
            qB.delete();
        end
    endtask

    initial begin
        vec_t v;
        int   n;
        // useB, C, N, E, S, W, expVal, expSat
        vecs[0]  = '{1'b0, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 1'b0}; // uniform
        vecs[1]  = '{1'b0, 8'd10,  8'd9,   8'd10,  8'd10,  8'd10,  8'd9,   1'b0}; // diff -1 floors to -1
        vecs[2]  = '{1'b1, 8'd0,   8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b1}; // 510 clamps high
        vecs[3]  = '{1'b1, 8'd200, 8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   1'b1}; // -200 clamps low
        vecs[4]  = '{1'b0, 8'd0,   8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0}; // exactly 255
        vecs[5]  = '{1'b0, 8'd50,  8'd200, 8'd0,   8'd0,   8'd0,   8'd50,  1'b0}; // diff 0
        vecs[6]  = '{1'b0, 8'd255, 8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   1'b0}; // exactly 0
        vecs[7]  = '{1'b1, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0}; // uniform max
        vecs[8]  = '{1'b0, 8'd20,  8'd21,  8'd21,  8'd21,  8'd21,  8'd21,  1'b0}; // +4>>>2 = +1
        vecs[9]  = '{1'b0, 8'd20,  8'd19,  8'd19,  8'd19,  8'd19,  8'd19,  1'b0}; // -4>>>2 = -1
        vecs[10] = '{1'b0, 8'd7,   8'd0,   8'd7,   8'd7,   8'd7,   8'd5,   1'b0}; // -7>>>2 = -2
        vecs[11] = '{1'b1, 8'd1,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   1'b1}; // result -1
        vecs[12] = '{1'b1, 8'd3,   8'd1,   8'd0,   8'd0,   8'd0,   8'd0,   1'b1}; // -11>>>1 = -6, -3

        resetN = 1'b0;
        startA = 1'b0; startB = 1'b0;
        cA = 8'd0; nA = 8'd0; eA = 8'd0; sA = 8'd0; wA = 8'd0;
        cB = 8'd0; nB = 8'd0; eB = 8'd0; sB = 8'd0; wB = 8'd0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst.NEXT_VAL",  {24'd0, nextA}, 32'd0);
        check("rst.Done",      {31'd0, doneA}, 32'd0);
        check("rst.Busy",      {31'd0, busyA}, 32'd0);
        check("rst.Saturated", {31'd0, satA},  32'd0);
        check("rst.GEN_COUNT", {24'd0, genA},  32'd0);
        resetN = 1'b1;
        @(negedge clk);

        // Table-driven vectors, plus a hold check two cycles after each Done
        foreach (vecs[i]) begin
            startPulse(vecs[i]);
            waitDrain(20);
            repeat (2) @(negedge clk);
            check("holdNEXT_VAL", {24'd0, (vecs[i].useB ? nextB : nextA)}, {24'd0, vecs[i].expVal});
            check("holdSaturated", {31'd0, (vecs[i].useB ? satB : satA)}, {31'd0, vecs[i].expSat});
        end

        // Snapshot / ignore: inputs change and Start re-pulses during ACC
        startPulse(vecs[0]);
        cA = 8'd0; nA = 8'd0; eA = 8'd0; sA = 8'd0; wA = 8'd0;
        startA = 1'b1;
        repeat (3) @(negedge clk);
        startA = 1'b0;
        waitDrain(20);
        repeat (8) @(negedge clk);

        // Back-to-back: Start held high; accepted again in each Done cycle,
        // so successive Done pulses are 6 edges apart (5 busy + 1 IDLE).
        @(negedge clk);
        cA = 8'd100; nA = 8'd100; eA = 8'd100; sA = 8'd100; wA = 8'd100;
        startA = 1'b1;
        for (int k = 0; k < 4; k++) pushExp(1'b0, 8'd100, 1'b0, cyc + 6 + 6 * k);
        repeat (6 * 3 + 1) @(negedge clk);
        startA = 1'b0;
        waitDrain(30);
        repeat (8) @(negedge clk);

        // Reset while ACC is at index 2 aborts the update
        v = vecs[1];
        startPulse(v);
        repeat (2) @(negedge clk);
        resetN = 1'b0;
        #1;
        qA.delete();
        qB.delete();
        modelGenA = 0;
        modelGenB = 0;
        check("midRst.NEXT_VAL",  {24'd0, nextA}, 32'd0);
        check("midRst.Done",      {31'd0, doneA}, 32'd0);
        check("midRst.Busy",      {31'd0, busyA}, 32'd0);
        check("midRst.Saturated", {31'd0, satA},  32'd0);
        check("midRst.GEN_COUNT", {24'd0, genA},  32'd0);
        check("midRst.B.GEN_COUNT", {24'd0, genB}, 32'd0);
        repeat (8) @(negedge clk);
        resetN = 1'b1;
        startPulse(vecs[8]);
        waitDrain(20);

        // Wrap: run updates until GEN_COUNT reaches 256 and returns to 0
        n = 256 - modelGenA;
        @(negedge clk);
        cA = 8'd20; nA = 8'd19; eA = 8'd19; sA = 8'd19; wA = 8'd19;
        startA = 1'b1;
        for (int k = 0; k < n; k++) pushExp(1'b0, 8'd19, 1'b0, cyc + 6 + 6 * k);
        repeat (6 * (n - 1) + 1) @(negedge clk);
        startA = 1'b0;
        waitDrain(30);
        check("wrap.GEN_COUNT", {24'd0, genA}, 32'd0);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    // Absolute time bound in case a wait never completes
    initial begin
        #1000000;
        $display("FAIL globalTimeout: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
